pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = pipeline side (drives hazard sources), slave = control unit.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic [4:0]       ex_dest;
  logic             ex_wb_en;
  logic             ex_mem_r_en;
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_if;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_all;
  logic             mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, ex_dest, ex_wb_en, ex_mem_r_en,
           mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
    input  freeze_if, flush_if_id, flush_id_ex, freeze_all, mem_timeout,
           state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, ex_dest, ex_wb_en, ex_mem_r_en,
           mem_dest, mem_wb_en, br_taken, mem_req, mem_ready,
    output freeze_if, flush_if_id, flush_id_ex, freeze_all, mem_timeout,
           state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: RAW/load-use stalls, branch flush,
// multicycle memory wait with watchdog, saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter bit FWD_EN  = 1'b1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
)(
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;

  state_t           state_q, state_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             raw_ex, raw_mem, hazard;
  logic             frz_if, fl_if_id, fl_id_ex, frz_all;

  // Register 0 is hardwired zero, so it never forms a dependency.
  assign raw_ex  = hz.ex_wb_en && (hz.ex_dest != 5'd0) &&
                   ((hz.ex_dest == hz.id_src1) || (hz.id_two_src && (hz.ex_dest == hz.id_src2)));
  assign raw_mem = hz.mem_wb_en && (hz.mem_dest != 5'd0) &&
                   ((hz.mem_dest == hz.id_src1) || (hz.id_two_src && (hz.mem_dest == hz.id_src2)));
  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard  = FWD_EN ? (raw_ex && hz.ex_mem_r_en) : (raw_ex || raw_mem);

  // Next state and control outputs; branch/hazard rules share one path for
  // RUN and the completing MEM_WAIT cycle.
  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_cnt;
    frz_if    = 1'b0;
    fl_if_id  = 1'b0;
    fl_id_ex  = 1'b0;
    frz_all   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          frz_all   = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd0;
        end else if (hz.br_taken) begin
          fl_if_id = 1'b1;
          fl_id_ex = 1'b1;
        end else if (hazard) begin
          frz_if   = 1'b1;
          fl_id_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          frz_all  = 1'b1;
          wait_nxt = wait_cnt + 8'd1;
          if (wait_cnt == 8'(TIMEOUT - 1)) state_nxt = ERROR;
        end else begin
          state_nxt = RUN;
          if (hz.br_taken) begin
            fl_if_id = 1'b1;
            fl_id_ex = 1'b1;
          end else if (hazard) begin
            frz_if   = 1'b1;
            fl_id_ex = 1'b1;
          end
        end
      end
      ERROR: frz_all = 1'b1;
      default: state_nxt = RUN;
    endcase
    // Reset must not leave the pipeline frozen or flushed.
    if (rst) begin
      frz_if   = 1'b0;
      fl_if_id = 1'b0;
      fl_id_ex = 1'b0;
      frz_all  = 1'b0;
    end
  end

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      wait_cnt  <= wait_nxt;
      if (state_nxt == ERROR) timeout_q <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((frz_if || frz_all) && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (fl_if_id && (flush_q != '1))            flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.freeze_if   = frz_if;
  assign hz.flush_if_id = fl_if_id;
  assign hz.flush_id_ex = fl_id_ex;
  assign hz.freeze_all  = frz_all;
  assign hz.mem_timeout = timeout_q;
  assign hz.state       = state_q;
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a (FWD_EN=1, TIMEOUT=4, CNT_W=4) and instance b
// (FWD_EN=0, defaults) see identical stimulus. Control vectors are compared
// as {freeze_if, flush_if_id, flush_id_ex, freeze_all}.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_src1, id_src2, ex_dest, mem_dest;
  logic       id_two_src, ex_wb_en, ex_mem_r_en, mem_wb_en, br_taken, mem_req, mem_ready;

  pipe_hazard_ctrl_if #(.CNT_W(4))  ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) ifb ();

  assign ifa.id_src1 = id_src1;         assign ifb.id_src1 = id_src1;
  assign ifa.id_src2 = id_src2;         assign ifb.id_src2 = id_src2;
  assign ifa.id_two_src = id_two_src;   assign ifb.id_two_src = id_two_src;
  assign ifa.ex_dest = ex_dest;         assign ifb.ex_dest = ex_dest;
  assign ifa.ex_wb_en = ex_wb_en;       assign ifb.ex_wb_en = ex_wb_en;
  assign ifa.ex_mem_r_en = ex_mem_r_en; assign ifb.ex_mem_r_en = ex_mem_r_en;
  assign ifa.mem_dest = mem_dest;       assign ifb.mem_dest = mem_dest;
  assign ifa.mem_wb_en = mem_wb_en;     assign ifb.mem_wb_en = mem_wb_en;
  assign ifa.br_taken = br_taken;       assign ifb.br_taken = br_taken;
  assign ifa.mem_req = mem_req;         assign ifb.mem_req = mem_req;
  assign ifa.mem_ready = mem_ready;     assign ifb.mem_ready = mem_ready;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .TIMEOUT(4), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .hz(ifa));
  pipe_hazard_ctrl #(.FWD_EN(1'b0))                         dut_b (.clk(clk), .rst(rst), .hz(ifb));

  logic [3:0] a_ctl, b_ctl;
  assign a_ctl = {ifa.freeze_if, ifa.flush_if_id, ifa.flush_id_ex, ifa.freeze_all};
  assign b_ctl = {ifb.freeze_if, ifb.flush_if_id, ifb.flush_id_ex, ifb.freeze_all};

  int errs = 0;
  int checks = 0;

  task automatic clear_inputs();
    id_src1 = '0; id_src2 = '0; id_two_src = 1'b0; ex_dest = '0; ex_wb_en = 1'b0;
    ex_mem_r_en = 1'b0; mem_dest = '0; mem_wb_en = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_use_inputs();
    ex_dest = 5'd5; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; id_src1 = 5'd5;
  endtask

  task automatic test_reset();
    @(negedge clk);
    load_use_inputs(); br_taken = 1'b1; mem_req = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (a_ctl !== 4'b0000) begin errs++; $display("FAIL reset_ctl_a: got %b want 0000", a_ctl); end
    checks++; if (b_ctl !== 4'b0000) begin errs++; $display("FAIL reset_ctl_b: got %b want 0000", b_ctl); end
    checks++; if ({ifa.state, ifa.mem_timeout, ifa.stall_cnt, ifa.flush_cnt} !== 11'd0) begin
      errs++; $display("FAIL reset_regs_a: state=%0d to=%b stall=%0d flush=%0d want all 0",
                       ifa.state, ifa.mem_timeout, ifa.stall_cnt, ifa.flush_cnt); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_inputs();
    #1;
    checks++; if (a_ctl !== 4'b1010) begin errs++; $display("FAIL lu_stall_a: got %b want 1010", a_ctl); end
    checks++; if (b_ctl !== 4'b1010) begin errs++; $display("FAIL lu_stall_b: got %b want 1010", b_ctl); end
    @(negedge clk);
    // load has moved to MEM
    ex_dest = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; mem_dest = 5'd5; mem_wb_en = 1'b1;
    #1;
    checks++; if (a_ctl !== 4'b0000) begin errs++; $display("FAIL lu_one_bubble_a: got %b want 0000", a_ctl); end
    checks++; if (ifa.stall_cnt !== 4'd1) begin errs++; $display("FAIL lu_stall_cnt_a: got %0d want 1", ifa.stall_cnt); end
    checks++; if (b_ctl !== 4'b1010) begin errs++; $display("FAIL lu_mem_raw_b: got %b want 1010", b_ctl); end
    @(negedge clk);
    // register 0 never hazards
    clear_inputs(); ex_wb_en = 1'b1; ex_mem_r_en = 1'b1; mem_wb_en = 1'b1;
    #1;
    checks++; if (a_ctl !== 4'b0000) begin errs++; $display("FAIL lu_r0_a: got %b want 0000", a_ctl); end
    checks++; if (b_ctl !== 4'b0000) begin errs++; $display("FAIL lu_r0_b: got %b want 0000", b_ctl); end
    checks++; if (ifb.stall_cnt !== 16'd2) begin errs++; $display("FAIL lu_stall_cnt_b: got %0d want 2", ifb.stall_cnt); end
  endtask

  task automatic test_fwd_off();
    do_reset();
    mem_dest = 5'd7; mem_wb_en = 1'b1; id_two_src = 1'b1; id_src2 = 5'd7; id_src1 = 5'd1;
    #1;
    checks++; if (b_ctl !== 4'b1010) begin errs++; $display("FAIL nofwd_src2_b: got %b want 1010", b_ctl); end
    checks++; if (a_ctl !== 4'b0000) begin errs++; $display("FAIL nofwd_src2_a: got %b want 0000", a_ctl); end
    @(negedge clk);
    id_two_src = 1'b0;
    #1;
    checks++; if (b_ctl !== 4'b0000) begin errs++; $display("FAIL nofwd_one_src_b: got %b want 0000", b_ctl); end
    @(negedge clk);
    clear_inputs(); ex_dest = 5'd3; ex_wb_en = 1'b1; id_src1 = 5'd3;
    #1;
    checks++; if (b_ctl !== 4'b1010) begin errs++; $display("FAIL nofwd_alu_ex_b: got %b want 1010", b_ctl); end
    checks++; if (a_ctl !== 4'b0000) begin errs++; $display("FAIL fwd_alu_ex_a: got %b want 0000", a_ctl); end
  endtask

  task automatic test_branch();
    do_reset();
    load_use_inputs(); br_taken = 1'b1;
    #1;
    checks++; if (a_ctl !== 4'b0110) begin errs++; $display("FAIL br_over_hz_a: got %b want 0110", a_ctl); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ifa.flush_cnt !== 4'd1) begin errs++; $display("FAIL br_flush_cnt_a: got %0d want 1", ifa.flush_cnt); end
    checks++; if (ifa.stall_cnt !== 4'd0) begin errs++; $display("FAIL br_stall_cnt_a: got %0d want 0", ifa.stall_cnt); end
  endtask

  task automatic test_multicycle();
    int frz;
    do_reset();
    mem_req = 1'b1;
    frz = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ifa.freeze_all === 1'b1) frz++;
      @(negedge clk);
    end
    mem_ready = 1'b1; br_taken = 1'b1;
    #1;
    checks++; if (frz !== 3) begin errs++; $display("FAIL mc_frozen_cycles: got %0d want 3", frz); end
    checks++; if (ifa.state !== 2'd1) begin errs++; $display("FAIL mc_wait_state: got %0d want 1", ifa.state); end
    checks++; if (a_ctl !== 4'b0110) begin errs++; $display("FAIL mc_ready_branch_a: got %b want 0110", a_ctl); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ifa.state !== 2'd0) begin errs++; $display("FAIL mc_back_run: got %0d want 0", ifa.state); end
    checks++; if (ifa.stall_cnt !== 4'd3) begin errs++; $display("FAIL mc_stall_cnt_a: got %0d want 3", ifa.stall_cnt); end
    checks++; if (ifb.stall_cnt !== 16'd3) begin errs++; $display("FAIL mc_stall_cnt_b: got %0d want 3", ifb.stall_cnt); end
    checks++; if (ifa.flush_cnt !== 4'd1) begin errs++; $display("FAIL mc_flush_cnt_a: got %0d want 1", ifa.flush_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    #1;
    checks++; if ({ifa.state, ifa.mem_timeout} !== 3'b010) begin
      errs++; $display("FAIL to_edge4_a: state=%0d to=%b want state=1 to=0", ifa.state, ifa.mem_timeout); end
    @(negedge clk);
    #1;
    checks++; if ({ifa.state, ifa.mem_timeout, ifa.freeze_all} !== 4'b1011) begin
      errs++; $display("FAIL to_edge5_a: state=%0d to=%b frz=%b want 2 1 1", ifa.state, ifa.mem_timeout, ifa.freeze_all); end
    checks++; if (ifb.state !== 2'd1) begin errs++; $display("FAIL to_long_b: got %0d want 1", ifb.state); end
    checks++; if (ifa.stall_cnt !== 4'd5) begin errs++; $display("FAIL to_stall_cnt_a: got %0d want 5", ifa.stall_cnt); end
    @(negedge clk);
    mem_ready = 1'b1; br_taken = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({ifa.state, ifa.mem_timeout, a_ctl} !== 7'b1010001) begin
      errs++; $display("FAIL to_sticky_a: state=%0d to=%b ctl=%b want 2 1 0001", ifa.state, ifa.mem_timeout, a_ctl); end
    rst = 1'b1;
    #1;
    checks++; if ({ifa.state, ifa.mem_timeout, a_ctl} !== 7'd0) begin
      errs++; $display("FAIL to_rst_a: state=%0d to=%b ctl=%b want all 0", ifa.state, ifa.mem_timeout, a_ctl); end
    checks++; if ({ifb.state, b_ctl} !== 6'd0) begin
      errs++; $display("FAIL to_rst_b: state=%0d ctl=%b want all 0", ifb.state, b_ctl); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({ifa.state, a_ctl, ifa.stall_cnt} !== 10'd0) begin
      errs++; $display("FAIL to_after_rst_a: state=%0d ctl=%b stall=%0d want 0", ifa.state, a_ctl, ifa.stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    load_use_inputs();
    for (int i = 0; i < 15; i++) @(negedge clk);
    #1;
    checks++; if (ifa.stall_cnt !== 4'd15) begin errs++; $display("FAIL sat_reach_a: got %0d want 15", ifa.stall_cnt); end
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    checks++; if (ifa.stall_cnt !== 4'd15) begin errs++; $display("FAIL sat_hold_a: got %0d want 15", ifa.stall_cnt); end
    checks++; if (ifb.stall_cnt !== 16'd20) begin errs++; $display("FAIL sat_wide_b: got %0d want 20", ifb.stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    br_taken = 1'b1;
    #1;
    checks++; if (a_ctl !== 4'b0110) begin errs++; $display("FAIL b2b_first_a: got %b want 0110", a_ctl); end
    @(negedge clk);
    mem_dest = 5'd9; mem_wb_en = 1'b1; id_src1 = 5'd9;
    #1;
    checks++; if (b_ctl !== 4'b0110) begin errs++; $display("FAIL b2b_second_b: got %b want 0110", b_ctl); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (ifb.flush_cnt !== 16'd2) begin errs++; $display("FAIL b2b_flush_cnt_b: got %0d want 2", ifb.flush_cnt); end
    checks++; if (ifb.stall_cnt !== 16'd0) begin errs++; $display("FAIL b2b_stall_cnt_b: got %0d want 0", ifb.stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_fwd_off();
    test_branch();
    test_multicycle();
    test_timeout();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
